// File: rtl/svm_kernel_accum.sv
// SVM kernel/accumulate stage: streams alpha ROM reads, applies a saturating
// degree-2 polynomial kernel per support vector, accumulates alpha*k, adds bias.
module svm_kernel_accum #(
   parameter int NBITS         = 8,
   parameter int LOG_F_WIDTH   = 5,
   parameter int SUP_WIDTH     = 64,
   parameter int LOG_SUP_WIDTH = 6,
   parameter int ALPHA_BITS    = 16,
   parameter int KBITS         = 16,
   parameter int KOFFSET       = 1,
   parameter int KSHIFT        = 8,
   parameter int ACC_BITS      = ALPHA_BITS + KBITS + 1 + LOG_SUP_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic signed [NBITS+LOG_F_WIDTH-1:0]    matmul1_result [0:SUP_WIDTH-1],
   output logic        [LOG_SUP_WIDTH-1:0]        alpha_addr,
   output logic                                   alpha_rd_en,
   input  logic signed [ALPHA_BITS-1:0]           alpha_data,
   input  logic signed [ACC_BITS-1:0]             bias,
   output logic                                   busy,
   output logic                                   done,
   output logic signed [ACC_BITS-1:0]             score,
   output logic                                   decision
);

   localparam int D  = NBITS + LOG_F_WIDTH;
   localparam int PW = ALPHA_BITS + KBITS + 1;
   localparam logic [LOG_SUP_WIDTH-1:0] LAST_IDX = LOG_SUP_WIDTH'(SUP_WIDTH - 1);
   localparam logic signed [D:0] KOFF_X = (D+1)'(KOFFSET);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, DONE} state_t;

   state_t                      state;
   logic                        drain_cnt;
   logic                        rd_d;
   logic [LOG_SUP_WIDTH-1:0]    addr_d;
   logic                        s1_vld;
   logic signed [ALPHA_BITS-1:0] s1_alpha;
   logic [KBITS-1:0]            s1_k;
   logic signed [ACC_BITS-1:0]  acc;

   logic                        accept;
   logic signed [D:0]           ksum;
   logic [D:0]                  kmag;
   logic [2*D+1:0]              ksq;
   logic [2*D+1:0]              ksh;
   logic [KBITS-1:0]            kval;
   logic signed [PW-1:0]        prod;
   logic signed [ACC_BITS-1:0]  prod_x;
   logic signed [ACC_BITS-1:0]  score_nxt;

   assign accept = start && (state == IDLE || state == DONE);

   // Kernel for the entry whose alpha is arriving this cycle; |s|^2 == s^2.
   assign ksum = {matmul1_result[addr_d][D-1], matmul1_result[addr_d]} + KOFF_X;
   assign kmag = ksum[D] ? (~ksum + (D+1)'(1)) : ksum;
   assign ksq  = {{(D+1){1'b0}}, kmag} * {{(D+1){1'b0}}, kmag};
   assign ksh  = ksq >> KSHIFT;
   assign kval = (|ksh[2*D+1:KBITS]) ? {KBITS{1'b1}} : ksh[KBITS-1:0];

   assign prod   = $signed({{(KBITS+1){s1_alpha[ALPHA_BITS-1]}}, s1_alpha})
                 * $signed({{ALPHA_BITS{1'b0}}, 1'b0, s1_k});
   assign prod_x = {{(ACC_BITS-PW){prod[PW-1]}}, prod};
   assign score_nxt = acc + bias;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         drain_cnt   <= 1'b0;
         alpha_addr  <= '0;
         alpha_rd_en <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         score       <= '0;
         decision    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state       <= RUN;
                  alpha_addr  <= '0;
                  alpha_rd_en <= 1'b1;
                  busy        <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (alpha_addr == LAST_IDX) begin
                  state       <= DRAIN;
                  alpha_rd_en <= 1'b0;
                  drain_cnt   <= 1'b0;
               end else begin
                  alpha_addr <= alpha_addr + LOG_SUP_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt) state <= BIAS;
               drain_cnt <= 1'b1;
            end
            BIAS: begin
               score    <= score_nxt;
               decision <= ~score_nxt[ACC_BITS-1];
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // S1 captures ROM data one cycle after its address; S2 accumulates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_d     <= 1'b0;
         addr_d   <= '0;
         s1_vld   <= 1'b0;
         s1_alpha <= '0;
         s1_k     <= '0;
         acc      <= '0;
      end else begin
         rd_d   <= alpha_rd_en;
         addr_d <= alpha_addr;
         s1_vld <= rd_d;
         if (rd_d) begin
            s1_alpha <= alpha_data;
            s1_k     <= kval;
         end
         if (accept)
            acc <= '0;
         else if (s1_vld)
            acc <= acc + prod_x;
      end
   end

endmodule

// File: tb/tb_svm_kernel_accum.sv
// Scoreboard bench: small instance (4 SVs, 4-bit kernel) for directed cases,
// default-parameter instance for shift/saturation and random ROM-driven vectors.
module tb_svm_kernel_accum;

   localparam int SUP_A = 4;
   localparam int ACC_A = 16 + 4 + 1 + 2;
   localparam int SUP_B = 64;
   localparam int ACC_B = 16 + 16 + 1 + 6;

   typedef struct {
      logic signed [63:0] score;
      logic               dec;
      int                 cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   int   pushed_a = 0, pushed_b = 0, done_cnt_a = 0, done_cnt_b = 0;

   logic                      start_a = 1'b0;
   logic signed [12:0]        res_a [0:SUP_A-1];
   logic signed [15:0]        rom_a [0:SUP_A-1];
   logic [1:0]                addr_a;
   logic                      rd_a;
   logic signed [15:0]        adat_a = '0;
   logic signed [ACC_A-1:0]   bias_a = '0;
   logic                      busy_a, done_a, dec_a;
   logic signed [ACC_A-1:0]   score_a;

   logic                      start_b = 1'b0;
   logic signed [12:0]        res_b [0:SUP_B-1];
   logic signed [15:0]        rom_b [0:SUP_B-1];
   logic [5:0]                addr_b;
   logic                      rd_b;
   logic signed [15:0]        adat_b = '0;
   logic signed [ACC_B-1:0]   bias_b = '0;
   logic                      busy_b, done_b, dec_b;
   logic signed [ACC_B-1:0]   score_b;

   svm_kernel_accum #(
      .NBITS(8), .LOG_F_WIDTH(5), .SUP_WIDTH(SUP_A), .LOG_SUP_WIDTH(2),
      .ALPHA_BITS(16), .KBITS(4), .KOFFSET(1), .KSHIFT(0)
   ) u_a (
      .clk(clk), .rst(rst), .start(start_a), .matmul1_result(res_a),
      .alpha_addr(addr_a), .alpha_rd_en(rd_a), .alpha_data(adat_a), .bias(bias_a),
      .busy(busy_a), .done(done_a), .score(score_a), .decision(dec_a)
   );

   svm_kernel_accum u_b (
      .clk(clk), .rst(rst), .start(start_b), .matmul1_result(res_b),
      .alpha_addr(addr_b), .alpha_rd_en(rd_b), .alpha_data(adat_b), .bias(bias_b),
      .busy(busy_b), .done(done_b), .score(score_b), .decision(dec_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency alpha ROMs
   always @(posedge clk) if (rd_a) adat_a <= rom_a[addr_a];
   always @(posedge clk) if (rd_b) adat_b <= rom_b[addr_b];

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done_a) begin
         done_cnt_a++;
         if (q_a.size() == 0) chk("A_unexpected_done", 64'sd1, 64'sd0);
         else begin
            e = q_a.pop_front();
            chk("A_score", score_a, e.score);
            chk("A_decision", {63'b0, dec_a}, {63'b0, e.dec});
            chk("A_done_cycle", cyc, e.cyc);
         end
      end
      if (done_b) begin
         done_cnt_b++;
         if (q_b.size() == 0) chk("B_unexpected_done", 64'sd1, 64'sd0);
         else begin
            e = q_b.pop_front();
            chk("B_score", score_b, e.score);
            chk("B_decision", {63'b0, dec_b}, {63'b0, e.dec});
            chk("B_done_cycle", cyc, e.cyc);
         end
      end
   end

   function automatic longint kern_ref(longint r, int koff, int kshift, int kbits);
      longint s, sq, mx;
      s  = r + koff;
      sq = (s * s) >> kshift;
      mx = (longint'(1) << kbits) - 1;
      return (sq > mx) ? mx : sq;
   endfunction

   task automatic set_a(input int r0, r1, r2, r3, input int a0, a1, a2, a3, input int b);
      res_a[0] = 13'(r0); res_a[1] = 13'(r1); res_a[2] = 13'(r2); res_a[3] = 13'(r3);
      rom_a[0] = 16'(a0); rom_a[1] = 16'(a1); rom_a[2] = 16'(a2); rom_a[3] = 16'(a3);
      bias_a = ACC_A'(b);
   endtask

   // Called at a negedge; start is high for exactly the current cycle.
   task automatic run_a(input longint exp_score, input bit push);
      start_a = 1'b1;
      if (push) begin
         q_a.push_back('{exp_score, exp_score >= 0, cyc + SUP_A + 4});
         pushed_a++;
      end
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic run_b(input longint exp_score);
      start_b = 1'b1;
      q_b.push_back('{exp_score, exp_score >= 0, cyc + SUP_B + 4});
      pushed_b++;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", (n >= 1000) ? 64'sd1 : 64'sd0, 64'sd0);
      @(negedge clk);
   endtask

   initial begin
      longint exp_s;
      for (int i = 0; i < SUP_A; i++) begin res_a[i] = '0; rom_a[i] = '0; end
      for (int i = 0; i < SUP_B; i++) begin res_b[i] = '0; rom_b[i] = '0; end

      repeat (3) @(negedge clk);
      chk("rst_busy", {63'b0, busy_a}, 0);
      chk("rst_done", {63'b0, done_a}, 0);
      chk("rst_score", score_a, 0);
      chk("rst_decision", {63'b0, dec_a}, 0);
      chk("rst_rd_en", {63'b0, rd_a}, 0);
      chk("rst_addr", {62'b0, addr_a}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic run: kernels 4,9,0,1 -> -2, bias -2
      set_a(1, 2, -1, 0, 1, -1, 2, 3, -2);
      run_a(-4, 1);
      for (int k = 1; k <= 8; k++) begin
         chk("busy_profile", {63'b0, busy_a}, (k <= 7) ? 64'sd1 : 64'sd0);
         chk("rd_en_profile", {63'b0, rd_a}, (k <= 4) ? 64'sd1 : 64'sd0);
         if (k <= 4) chk("addr_seq", {62'b0, addr_a}, k - 1);
         @(negedge clk);
      end
      wait_idle();

      set_a(1, 2, -1, 0, 1, -1, 2, 3, 5);
      run_a(3, 1); wait_idle();
      set_a(1, 2, -1, 0, 1, -1, 2, 3, 2);
      run_a(0, 1); wait_idle();

      // Saturation: 64 -> 15, and 16 -> 15 boundary
      set_a(7, 0, 0, 0, 1, 0, 0, 0, 3);
      run_a(18, 1); wait_idle();
      set_a(-5, 2, 0, 0, 2, 1, 0, 0, -40);
      run_a(-1, 1); wait_idle();

      // Back-to-back: start in the DONE cycle
      set_a(1, 2, -1, 0, 1, -1, 2, 3, -2);
      run_a(-4, 1);
      repeat (7) @(negedge clk);
      set_a(0, 0, 1, 2, 4, 0, -3, 2, 10);
      run_a(20, 1);
      wait_idle();

      // Start pulses while busy are ignored
      set_a(1, 1, 1, 1, 1, 1, 1, 1, 0);
      run_a(16, 1);
      @(negedge clk);
      run_a(0, 0);
      repeat (3) @(negedge clk);
      run_a(0, 0);
      wait_idle();

      // Reset mid-run aborts without done
      set_a(1, 2, -1, 0, 1, -1, 2, 3, -2);
      run_a(0, 0);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", {63'b0, busy_a}, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", {63'b0, busy_a}, 0);
      chk("mid_rst_rd_en", {63'b0, rd_a}, 0);
      chk("mid_rst_addr", {62'b0, addr_a}, 0);
      chk("mid_rst_score", score_a, 0);
      chk("mid_rst_done", {63'b0, done_a}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      set_a(1, 2, -1, 0, 1, -1, 2, 3, 5);
      run_a(3, 1); wait_idle();

      // Default instance: shift and saturation at 65535
      res_b[0] = 13'sd4095;  rom_b[0] = 16'sd2;
      res_b[1] = 13'sd15;    rom_b[1] = -16'sd7;
      res_b[63] = -13'sd4096; rom_b[63] = -16'sd1;
      for (int i = 2; i < 63; i++) rom_b[i] = 16'sd5;
      bias_b = ACC_B'(100);
      run_b(65659); wait_idle();

      // Random vectors against the reference model
      for (int v = 0; v < 100; v++) begin
         exp_s = 0;
         for (int i = 0; i < SUP_B; i++) begin
            res_b[i] = 13'(int'($urandom_range(0, 8191)) - 4096);
            rom_b[i] = 16'($urandom_range(0, 65535));
            exp_s += longint'(rom_b[i]) * kern_ref(longint'(res_b[i]), 1, 8, 16);
         end
         bias_b = ACC_B'(int'($urandom_range(0, 2097152)) - 1048576);
         exp_s += longint'(bias_b);
         run_b(exp_s);
         wait_idle();
      end

      chk("A_done_count", done_cnt_a, pushed_a);
      chk("B_done_count", done_cnt_b, pushed_b);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
